// File: rtl/fns_dec_sched_if.sv
// Handshake bundle between NLANE codeword sources, the shared FNS decoder and
// the downstream consumer of decoded results.
interface fns_dec_sched_if #(
  parameter int NLANE = 4,
  parameter int CW    = 29,
  parameter int DW    = 22,
  parameter int LW    = 2
);
  logic [NLANE-1:0]    in_valid;
  logic [NLANE-1:0]    in_ready;
  logic [NLANE*CW-1:0] in_code;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [LW-1:0]       out_lane;
  logic                busy;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_lane, busy
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_lane, busy
  );
endinterface

// File: rtl/fns_dec_sched.sv
// Round-robin shared bit-serial Fibonacci-numeral-system decoder: grants one
// lane, decodes its CW-bit codeword LSB-first over CW cycles, then holds the result.
module fns_dec_sched #(
  parameter int NLANE = 4,
  parameter int CW    = 29,
  parameter int DW    = 22,
  parameter int LW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  fns_dec_sched_if.slave bus
);

  localparam int CNT_W = $clog2(CW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_shreg;
  logic [DW-1:0]    r_acc;
  logic [DW-1:0]    r_wa;
  logic [DW-1:0]    r_wb;
  logic [CNT_W-1:0] r_cnt;
  logic [LW-1:0]    r_lane;
  logic [LW-1:0]    r_last;

  logic             w_any;
  logic [LW-1:0]    w_grant;
  logic             w_start;
  logic [NLANE-1:0] w_in_ready;

  // Search from the lane after the last winner; descending offsets so the
  // nearest requester overwrites any farther one.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int off = NLANE; off >= 1; off--) begin
      if (bus.in_valid[(int'(r_last) + off) % NLANE]) begin
        w_any   = 1'b1;
        w_grant = LW'((int'(r_last) + off) % NLANE);
      end
    end
  end

  assign w_start = (r_state == IDLE) && w_any;

  always_comb begin
    w_in_ready = '0;
    if (w_start) begin
      w_in_ready[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_W'(CW - 1)) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control and result registers: cleared by reset, discarding any decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_last  <= LW'(NLANE - 1);
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_lane <= w_grant;
            r_last <= w_grant;
          end
        end
        RUN: begin
          if (r_shreg[0]) begin
            r_acc <= r_acc + r_wa;
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Serial datapath: shift register plus the running Fibonacci weight pair.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_shreg <= bus.in_code[w_grant*CW +: CW];
      r_wa    <= DW'(1);
      r_wb    <= DW'(2);
    end else if (r_state == RUN) begin
      r_shreg <= r_shreg >> 1;
      r_wa    <= r_wb;
      r_wb    <= r_wa + r_wb;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_acc;
  assign bus.out_lane  = r_lane;
  assign bus.busy      = (r_state != IDLE);

endmodule
